// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol width, control-period codes, the stage-1
// record passed to the disparity stage, and small bit-counting helpers.
package tmds_pkg;

  localparam int SYM_W = 10;

  localparam logic [SYM_W-1:0] CTRL_00 = 10'h354;
  localparam logic [SYM_W-1:0] CTRL_01 = 10'h0AB;
  localparam logic [SYM_W-1:0] CTRL_10 = 10'h154;
  localparam logic [SYM_W-1:0] CTRL_11 = 10'h2AB;

  typedef struct packed {
    logic [8:0] qm;
    logic [3:0] n1;
    logic       de;
    logic [1:0] ctrl;
  } qm_stage_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [SYM_W-1:0] ctrl_code(input logic [1:0] c);
    logic [SYM_W-1:0] code;
    case (c)
      2'b00:   code = CTRL_00;
      2'b01:   code = CTRL_01;
      2'b10:   code = CTRL_10;
      2'b11:   code = CTRL_11;
      default: code = CTRL_00;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// Stage 1 of the TMDS encoder: transition-minimised q_m word, its ones count,
// and the delayed de/ctrl that travel alongside it.
module tmds_qm_stage
  import tmds_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] data_i,
  input  logic [1:0] ctrl_i,
  input  logic       de_i,
  output qm_stage_t  stage_o
);

  logic [3:0] n1d_s;
  logic       use_xnor_s;
  logic [8:0] qm_s;
  qm_stage_t  stage_r;

  // Choose XOR/XNOR chaining to minimise transitions in the byte.
  always_comb begin
    n1d_s      = popcount8(data_i);
    use_xnor_s = (n1d_s > 4'd4) || ((n1d_s == 4'd4) && (data_i[0] == 1'b0));
    qm_s       = 9'd0;
    qm_s[0]    = data_i[0];
    for (int i = 1; i < 8; i++) begin
      if (use_xnor_s) begin
        qm_s[i] = ~(qm_s[i-1] ^ data_i[i]);
      end else begin
        qm_s[i] = qm_s[i-1] ^ data_i[i];
      end
    end
    qm_s[8] = ~use_xnor_s;
  end

  // Stage-1 pipeline register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stage_r <= '{qm: 9'd0, n1: 4'd0, de: 1'b0, ctrl: 2'b00};
    end else begin
      stage_r <= '{qm: qm_s, n1: popcount8(qm_s[7:0]), de: de_i, ctrl: ctrl_i};
    end
  end

  assign stage_o = stage_r;

endmodule

// File: rtl/tmds_channel_encoder.sv
// Single-channel DVI/TMDS 8b/10b encoder: two-stage pipeline producing a
// DC-balanced 10-bit symbol per pixel clock, with control-period codes.
module tmds_channel_encoder
  import tmds_pkg::*;
#(
  parameter int DISP_W = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [7:0]               data_i,
  input  logic [1:0]               ctrl_i,
  input  logic                     de_i,
  output logic [SYM_W-1:0]         tmds_o,
  output logic signed [DISP_W-1:0] disp_o
);

  localparam logic signed [DISP_W-1:0] ZERO = {DISP_W{1'b0}};
  localparam logic signed [DISP_W-1:0] TWO  = DISP_W'(5'sd2);
  localparam logic signed [DISP_W-1:0] EIGHT = DISP_W'(5'sd8);

  qm_stage_t                stage_s;
  logic                     q8_s;
  logic [7:0]               qm8_s;
  logic signed [DISP_W-1:0] n1_s;
  logic signed [DISP_W-1:0] n0_s;
  logic                     cnt_pos_s;
  logic                     cnt_neg_s;
  logic [SYM_W-1:0]         sym_nx_s;
  logic signed [DISP_W-1:0] cnt_nx_s;
  logic [SYM_W-1:0]         tmds_r;
  logic signed [DISP_W-1:0] cnt_r;

  tmds_qm_stage u_qm_stage (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .data_i  (data_i),
    .ctrl_i  (ctrl_i),
    .de_i    (de_i),
    .stage_o (stage_s)
  );

  // Stage 2: pick the inversion that pulls running disparity back toward zero.
  always_comb begin
    q8_s      = stage_s.qm[8];
    qm8_s     = stage_s.qm[7:0];
    n1_s      = DISP_W'($signed({1'b0, stage_s.n1}));
    n0_s      = EIGHT - n1_s;
    cnt_pos_s = !cnt_r[DISP_W-1] && (cnt_r != ZERO);
    cnt_neg_s = cnt_r[DISP_W-1];
    sym_nx_s  = CTRL_00;
    cnt_nx_s  = ZERO;
    if (!stage_s.de) begin
      sym_nx_s = ctrl_code(stage_s.ctrl);
      cnt_nx_s = ZERO;
    end else if ((cnt_r == ZERO) || (stage_s.n1 == 4'd4)) begin
      sym_nx_s = {~q8_s, q8_s, (q8_s ? qm8_s : ~qm8_s)};
      cnt_nx_s = q8_s ? (cnt_r + n1_s - n0_s) : (cnt_r + n0_s - n1_s);
    end else if ((cnt_pos_s && (stage_s.n1 > 4'd4)) || (cnt_neg_s && (stage_s.n1 < 4'd4))) begin
      sym_nx_s = {1'b1, q8_s, ~qm8_s};
      cnt_nx_s = cnt_r + (q8_s ? TWO : ZERO) + n0_s - n1_s;
    end else begin
      sym_nx_s = {1'b0, q8_s, qm8_s};
      cnt_nx_s = cnt_r - (q8_s ? ZERO : TWO) + n1_s - n0_s;
    end
  end

  // Output symbol and running-disparity registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmds_r <= CTRL_00;
      cnt_r  <= ZERO;
    end else begin
      tmds_r <= sym_nx_s;
      cnt_r  <= cnt_nx_s;
    end
  end

  assign tmds_o = tmds_r;
  assign disp_o = cnt_r;

endmodule
